// File: rtl/turf_pkg.sv
// Shared types and constants for the turf-painting game: round states,
// paint-RAM geometry and the colour codes stored in the paint RAM.
package turf_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        PLAY   = 3'd2,
        TALLY  = 3'd3,
        RESULT = 3'd4
    } round_state_t;

    localparam logic [14:0] PAINT_MAX_ADDR = 15'b10011110_1110111;

    localparam logic [2:0] BLANK = 3'b000;
    localparam logic [2:0] P1    = 3'b001;
    localparam logic [2:0] P2    = 3'b010;
    localparam logic [2:0] P3    = 3'b100;
    localparam logic [2:0] P4    = 3'b110;

endpackage

// File: rtl/round_controller_rise_detect.sv
// Registered rising-edge detector; the previous-value register resets to
// RESET_VAL so a level already high at reset release is not seen as an edge.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev_r;

    // Previous-cycle copy of the input level
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= RESET_VAL;
        end else begin
            prev_r <= din;
        end
    end

    assign rise = din & ~prev_r;

endmodule

// File: rtl/round_controller.sv
// Game-round sequencer: clears the paint RAM, runs a timed round, triggers
// the tally and holds the winner until the next start request.
module round_controller
    import turf_pkg::*;
#(
    parameter int ROUND_TICKS = 80,
    parameter int MAX_ADDR    = 20343,
    parameter int ADDR_W      = 15
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start_req,
    input  logic              tick,
    input  logic              tally_done,
    input  logic [1:0]        winner,
    output logic              running,
    output logic              tally_start,
    output logic              clr_wren,
    output logic [ADDR_W-1:0] clr_address,
    output logic [2:0]        clr_data,
    output logic [7:0]        ticks_left,
    output logic [1:0]        winner_q,
    output logic              winner_valid
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MAX_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO  = ADDR_W'(0);
    localparam logic [7:0]        TICKS_INIT = 8'(ROUND_TICKS);

    round_state_t      state_r, state_n;
    logic              start_rise_s;
    logic              running_r, running_n;
    logic              tally_start_r, tally_start_n;
    logic              clr_wren_r, clr_wren_n;
    logic [ADDR_W-1:0] clr_address_r, clr_address_n;
    logic [7:0]        ticks_left_r, ticks_left_n;
    logic [1:0]        winner_q_r, winner_q_n;
    logic              winner_valid_r, winner_valid_n;

    rise_detect #(.RESET_VAL(1'b1)) u_start_rise (
        .clk   (CLOCK_50),
        .reset (reset),
        .din   (start_req),
        .rise  (start_rise_s)
    );

    // Next-state and next-output logic; every output is registered
    always_comb begin
        state_n        = state_r;
        running_n      = running_r;
        tally_start_n  = 1'b0;
        clr_wren_n     = clr_wren_r;
        clr_address_n  = clr_address_r;
        ticks_left_n   = ticks_left_r;
        winner_q_n     = winner_q_r;
        winner_valid_n = winner_valid_r;
        case (state_r)
            IDLE: begin
                if (start_rise_s) begin
                    state_n       = CLEAR;
                    clr_wren_n    = 1'b1;
                    clr_address_n = ADDR_ZERO;
                end else begin
                    state_n = IDLE;
                end
            end
            CLEAR: begin
                if (clr_address_r >= LAST_ADDR) begin
                    state_n       = PLAY;
                    clr_wren_n    = 1'b0;
                    clr_address_n = ADDR_ZERO;
                    ticks_left_n  = TICKS_INIT;
                    running_n     = 1'b1;
                end else begin
                    clr_address_n = clr_address_r + ADDR_ONE;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (ticks_left_r <= 8'd1) begin
                        state_n       = TALLY;
                        ticks_left_n  = 8'd0;
                        running_n     = 1'b0;
                        tally_start_n = 1'b1;
                    end else begin
                        ticks_left_n = ticks_left_r - 8'd1;
                    end
                end else begin
                    ticks_left_n = ticks_left_r;
                end
            end
            TALLY: begin
                // tally_start_r marks the first TALLY cycle, where a stale done is ignored
                if (!tally_start_r && tally_done) begin
                    state_n        = RESULT;
                    winner_q_n     = winner;
                    winner_valid_n = 1'b1;
                end else begin
                    state_n = TALLY;
                end
            end
            RESULT: begin
                if (start_rise_s) begin
                    state_n        = CLEAR;
                    winner_valid_n = 1'b0;
                    clr_wren_n     = 1'b1;
                    clr_address_n  = ADDR_ZERO;
                end else begin
                    state_n = RESULT;
                end
            end
            default: begin
                state_n        = IDLE;
                running_n      = 1'b0;
                clr_wren_n     = 1'b0;
                clr_address_n  = ADDR_ZERO;
                winner_valid_n = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r        <= IDLE;
            running_r      <= 1'b0;
            tally_start_r  <= 1'b0;
            clr_wren_r     <= 1'b0;
            clr_address_r  <= ADDR_ZERO;
            ticks_left_r   <= 8'd0;
            winner_q_r     <= 2'b00;
            winner_valid_r <= 1'b0;
        end else begin
            state_r        <= state_n;
            running_r      <= running_n;
            tally_start_r  <= tally_start_n;
            clr_wren_r     <= clr_wren_n;
            clr_address_r  <= clr_address_n;
            ticks_left_r   <= ticks_left_n;
            winner_q_r     <= winner_q_n;
            winner_valid_r <= winner_valid_n;
        end
    end

    assign running      = running_r;
    assign tally_start  = tally_start_r;
    assign clr_wren     = clr_wren_r;
    assign clr_address  = clr_address_r;
    assign clr_data     = BLANK;
    assign ticks_left   = ticks_left_r;
    assign winner_q     = winner_q_r;
    assign winner_valid = winner_valid_r;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: a small instance (3 ticks, 16-word
// clear) for the round sequence plus a default instance for the full clear sweep.
module tb_round_controller;

    logic        clk;
    logic        reset;
    logic        start_req;
    logic        tick;
    logic        tally_done;
    logic [1:0]  winner;
    logic        running;
    logic        tally_start;
    logic        clr_wren;
    logic [14:0] clr_address;
    logic [2:0]  clr_data;
    logic [7:0]  ticks_left;
    logic [1:0]  winner_q;
    logic        winner_valid;

    logic        f_start;
    logic        f_tick;
    logic        f_done;
    logic [1:0]  f_winner;
    logic        f_running;
    logic        f_tally_start;
    logic        f_wren;
    logic [14:0] f_addr;
    logic [2:0]  f_data;
    logic [7:0]  f_ticks;
    logic [1:0]  f_wq;
    logic        f_wvalid;

    int n_tests = 0;
    int n_fail  = 0;

    round_controller #(.ROUND_TICKS(3), .MAX_ADDR(15), .ADDR_W(15)) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .start_req    (start_req),
        .tick         (tick),
        .tally_done   (tally_done),
        .winner       (winner),
        .running      (running),
        .tally_start  (tally_start),
        .clr_wren     (clr_wren),
        .clr_address  (clr_address),
        .clr_data     (clr_data),
        .ticks_left   (ticks_left),
        .winner_q     (winner_q),
        .winner_valid (winner_valid)
    );

    round_controller dut_full (
        .CLOCK_50     (clk),
        .reset        (reset),
        .start_req    (f_start),
        .tick         (f_tick),
        .tally_done   (f_done),
        .winner       (f_winner),
        .running      (f_running),
        .tally_start  (f_tally_start),
        .clr_wren     (f_wren),
        .clr_address  (f_addr),
        .clr_data     (f_data),
        .ticks_left   (f_ticks),
        .winner_q     (f_wq),
        .winner_valid (f_wvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // advance one clock edge and settle past it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int last_addr;
        reset = 1'b1; start_req = 1'b0; tick = 1'b0; tally_done = 1'b0; winner = 2'b00;
        f_start = 1'b0; f_tick = 1'b0; f_done = 1'b0; f_winner = 2'b00;
        repeat (3) cyc();
        check_value("rst_running", running, 0);
        check_value("rst_tally_start", tally_start, 0);
        check_value("rst_clr_wren", clr_wren, 0);
        check_value("rst_clr_address", clr_address, 0);
        check_value("rst_ticks_left", ticks_left, 0);
        check_value("rst_winner_q", winner_q, 0);
        check_value("rst_winner_valid", winner_valid, 0);

        reset = 1'b0;
        cyc();
        tick = 1'b1; tally_done = 1'b1;
        cyc();
        tick = 1'b0; tally_done = 1'b0;
        check_value("idle_ignore_wren", clr_wren, 0);
        check_value("idle_ignore_valid", winner_valid, 0);
        check_value("idle_ignore_ticks", ticks_left, 0);

        start_req = 1'b1;
        cyc();
        for (int i = 0; i < 16; i++) begin
            check_value("clear_wren", clr_wren, 1);
            check_value("clear_addr", clr_address, i);
            check_value("clear_data", clr_data, 0);
            check_value("clear_running", running, 0);
            if (i == 15) tick = 1'b1;
            cyc();
        end
        tick = 1'b0;
        check_value("play_running", running, 1);
        check_value("play_ticks_init", ticks_left, 3);
        check_value("play_wren", clr_wren, 0);
        check_value("play_addr", clr_address, 0);

        start_req = 1'b0;
        cyc();
        start_req = 1'b1;
        cyc();
        check_value("play_no_restart_wren", clr_wren, 0);
        check_value("play_no_restart_ticks", ticks_left, 3);

        for (int k = 0; k < 3; k++) begin
            repeat (4) cyc();
            if (k == 2) begin
                tally_done = 1'b1;
                winner = 2'b10;
            end
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            check_value("tick_count", ticks_left, 2 - k);
            if (k < 2) check_value("tick_running", running, 1);
        end
        check_value("tally_running", running, 0);
        check_value("tally_start_pulse", tally_start, 1);
        check_value("tally_first_valid", winner_valid, 0);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        check_value("tally_start_single", tally_start, 0);
        check_value("tally_no_early_capture", winner_valid, 0);
        check_value("tally_ticks_zero", ticks_left, 0);
        cyc();
        check_value("result_valid", winner_valid, 1);
        check_value("result_winner", winner_q, 2);
        tally_done = 1'b0;

        start_req = 1'b0;
        cyc();
        start_req = 1'b1;
        cyc();
        check_value("restart_valid_low", winner_valid, 0);
        check_value("restart_winner_held", winner_q, 2);
        check_value("restart_wren", clr_wren, 1);
        repeat (7) cyc();
        check_value("abort_addr_before", clr_address, 7);
        reset = 1'b1;
        cyc();
        check_value("abort_wren", clr_wren, 0);
        check_value("abort_addr", clr_address, 0);
        reset = 1'b0;
        repeat (3) cyc();
        check_value("held_start_no_round", clr_wren, 0);
        start_req = 1'b0;
        cyc();
        start_req = 1'b1;
        cyc();
        check_value("fresh_start_wren", clr_wren, 1);
        check_value("fresh_start_addr", clr_address, 0);

        repeat (16) cyc();
        check_value("round2_running", running, 1);
        check_value("round2_ticks", ticks_left, 3);
        winner = 2'b01;
        tally_done = 1'b1;
        tick = 1'b1;
        repeat (3) cyc();
        tick = 1'b0;
        check_value("round2_tally_start", tally_start, 1);
        check_value("round2_running_low", running, 0);
        repeat (2) cyc();
        check_value("round2_valid", winner_valid, 1);
        check_value("round2_winner", winner_q, 1);
        tally_done = 1'b0;
        start_req = 1'b0;
        cyc();
        start_req = 1'b1;
        cyc();
        check_value("round2_restart_valid", winner_valid, 0);
        check_value("round2_winner_held", winner_q, 1);

        f_start = 1'b1;
        cyc();
        cnt = 0;
        last_addr = -1;
        while (f_wren && cnt < 30000) begin
            cnt++;
            last_addr = int'(f_addr);
            cyc();
        end
        check_value("full_clear_cycles", cnt, 20344);
        check_value("full_clear_last_addr", last_addr, 20343);
        check_value("full_play_running", f_running, 1);
        check_value("full_play_ticks", f_ticks, 80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
